// File: rtl/calc_pkg.sv
// Shared types and constants for the 8-bit calculator sequencer.
package calc_pkg;

   localparam int CALC_W = 8;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_AND = 3'd3,
      OP_OR  = 3'd4,
      OP_NOT = 3'd5,
      OP_XOR = 3'd6,
      OP_CLR = 3'd7
   } calc_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2
   } calc_state_e;

   // Command as captured at acceptance; later input changes cannot reach it.
   typedef struct packed {
      calc_op_e          op;
      logic [CALC_W-1:0] a;
      logic [CALC_W-1:0] b;
   } calc_cmd_t;

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Command/result bus between a requester (master) and the sequencer (slave).
interface calc_op_sequencer_if;
   import calc_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic              cmd_uas;
   logic [CALC_W-1:0] in1;
   logic [CALC_W-1:0] in2;
   logic [CALC_W-1:0] out;
   logic              res_valid;
   logic              carry;
   logic              ovf;
   logic              zero;
   logic              err;

   modport master (
      output cmd_valid, cmd_op, cmd_uas, in1, in2,
      input  cmd_ready, out, res_valid, carry, ovf, zero, err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_uas, in1, in2,
      output cmd_ready, out, res_valid, carry, ovf, zero, err
   );

endinterface

// File: rtl/calc_mul_shift.sv
// Iterative shift-add multiplier: one partial-product step per cycle after start.
module calc_mul_shift
   import calc_pkg::*;
#(
   parameter int W     = CALC_W,
   parameter int STEPS = CALC_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   localparam int CW = $clog2(STEPS);

   logic [2*W-1:0] mcand;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] addend;
   logic [W-1:0]   mplier;
   logic [CW-1:0]  step;

   // product is the accumulator after the current step, so the final value
   // is available in the same cycle that done is high.
   assign addend  = mplier[0] ? mcand : '0;
   assign product = acc + addend;
   assign done    = busy && (step == CW'(STEPS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         step   <= '0;
         busy   <= 1'b0;
      end else if (busy) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         step   <= done ? '0 : step + 1'b1;
         if (done) busy <= 1'b0;
      end else if (start) begin
         mcand  <= {{W{1'b0}}, a};
         acc    <= '0;
         mplier <= b;
         step   <= '0;
         busy   <= 1'b1;
      end
   end

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator command sequencer: operand select, single-cycle ALU, saved result and flags.
// Define CALC_MUL_EN to build the iterative MUL path; otherwise opcode 2 is illegal.
module calc_op_sequencer
   import calc_pkg::*;
#(
   parameter int WIDTH     = CALC_W,
   parameter int MUL_STEPS = CALC_W
) (
   input logic                clk,
   input logic                rst,
   calc_op_sequencer_if.slave bus
);

   if (WIDTH != CALC_W || MUL_STEPS != WIDTH) begin : g_bad_cfg
      $error("calc_op_sequencer supports only WIDTH = MUL_STEPS = 8");
   end

   calc_state_e      state;
   calc_cmd_t        cmd_q;
   logic [WIDTH-1:0] out_q;
   logic             ready_q, res_valid_q, carry_q, zero_q, err_q;

   logic             accept;
   calc_op_e         op_in;
   logic [WIDTH-1:0] a_sel, b_sel;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] exec_res;
   logic             exec_carry, exec_zero, exec_err;

   assign accept = bus.cmd_valid && ready_q;
   assign op_in  = calc_op_e'(bus.cmd_op);
   assign a_sel  = bus.cmd_uas ? out_q   : bus.in1;
   assign b_sel  = bus.cmd_uas ? bus.in1 : bus.in2;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      sum        = {1'b0, cmd_q.a} + {1'b0, cmd_q.b};
      diff       = {1'b0, cmd_q.a} - {1'b0, cmd_q.b};
      exec_res   = out_q;
      exec_carry = 1'b0;
      exec_err   = 1'b0;
      case (cmd_q.op)
         OP_ADD: {exec_carry, exec_res} = sum;
         OP_SUB: {exec_carry, exec_res} = diff;
         OP_AND: exec_res = cmd_q.a & cmd_q.b;
         OP_OR:  exec_res = cmd_q.a | cmd_q.b;
         OP_NOT: exec_res = ~cmd_q.a;
         OP_XOR: exec_res = cmd_q.a ^ cmd_q.b;
         OP_CLR: exec_res = '0;
         default: exec_err = 1'b1;
      endcase
      // CLR forces zero low; an illegal op leaves out, and so zero, untouched.
      exec_zero = (exec_res == '0);
      if (cmd_q.op == OP_CLR) exec_zero = 1'b0;
      else if (exec_err)      exec_zero = zero_q;
   end

`ifdef CALC_MUL_EN
   logic               ovf_q;
   logic               mul_start, mul_busy, mul_done;
   logic [2*WIDTH-1:0] mul_product;

   assign mul_start = accept && (op_in == OP_MUL) && !mul_busy;

   calc_mul_shift #(.W(WIDTH), .STEPS(MUL_STEPS)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (a_sel),
      .b       (b_sel),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         cmd_q       <= '0;
         out_q       <= '0;
         ready_q     <= 1'b1;
         res_valid_q <= 1'b0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef CALC_MUL_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         res_valid_q <= 1'b0;
         unique case (state)
            ST_IDLE: if (accept) begin
               cmd_q   <= '{op: op_in, a: a_sel, b: b_sel};
               ready_q <= 1'b0;
`ifdef CALC_MUL_EN
               state   <= (op_in == OP_MUL) ? ST_MUL : ST_EXEC;
`else
               state   <= ST_EXEC;
`endif
            end
            ST_EXEC: begin
               out_q       <= exec_res;
               carry_q     <= exec_carry;
               zero_q      <= exec_zero;
               err_q       <= exec_err;
`ifdef CALC_MUL_EN
               ovf_q       <= 1'b0;
`endif
               res_valid_q <= 1'b1;
               ready_q     <= 1'b1;
               state       <= ST_IDLE;
            end
`ifdef CALC_MUL_EN
            ST_MUL: if (mul_done) begin
               out_q       <= mul_product[WIDTH-1:0];
               ovf_q       <= |mul_product[2*WIDTH-1:WIDTH];
               zero_q      <= (mul_product[WIDTH-1:0] == '0);
               carry_q     <= 1'b0;
               err_q       <= 1'b0;
               res_valid_q <= 1'b1;
               ready_q     <= 1'b1;
               state       <= ST_IDLE;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = ready_q;
   assign bus.out       = out_q;
   assign bus.res_valid = res_valid_q;
   assign bus.carry     = carry_q;
   assign bus.zero      = zero_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench: behavioural latency/result model, per-cycle compare, directed and random stimulus.
module tb_calc_op_sequencer;
   import calc_pkg::*;

`ifdef CALC_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   calc_op_sequencer_if bus();

   calc_op_sequencer #(.WIDTH(8), .MUL_STEPS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   typedef struct {
      int out;
      bit carry;
      bit ovf;
      bit zero;
      bit err;
   } res_t;

   function automatic res_t model_op(input int op, input int a, input int b, input res_t cur);
      res_t r;
      r.out = cur.out; r.carry = 1'b0; r.ovf = 1'b0; r.err = 1'b0; r.zero = cur.zero;
      case (op)
         0: begin r.out = (a + b) % 256; r.carry = (a + b) > 255; end
         1: begin r.out = (a - b + 256) % 256; r.carry = a < b; end
         2: if (MUL_ON) begin r.out = (a * b) % 256; r.ovf = (a * b) > 255; end
            else r.err = 1'b1;
         3: r.out = a & b;
         4: r.out = a | b;
         5: r.out = (~a) & 255;
         6: r.out = a ^ b;
         default: r.out = 0;
      endcase
      if (op == 7)     r.zero = 1'b0;
      else if (!r.err) r.zero = (r.out == 0);
      return r;
   endfunction

   // Model: a command is accepted when idle, its result lands 1 cycle later (8 for MUL).
   res_t m, m_pend;
   int   m_wait  = 0;
   bit   m_ready = 1'b1;
   bit   m_rv    = 1'b0;
   int   n_acc   = 0;
   int   n_rv    = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m       <= '{0, 1'b0, 1'b0, 1'b0, 1'b0};
         m_wait  <= 0;
         m_ready <= 1'b1;
         m_rv    <= 1'b0;
      end else begin
         m_rv <= 1'b0;
         if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
               m       <= m_pend;
               m_rv    <= 1'b1;
               m_ready <= 1'b1;
            end
         end else if (bus.cmd_valid) begin
            m_pend  <= model_op(int'(bus.cmd_op),
                                bus.cmd_uas ? m.out : int'(bus.in1),
                                bus.cmd_uas ? int'(bus.in1) : int'(bus.in2), m);
            m_wait  <= (bus.cmd_op == 3'd2 && MUL_ON) ? 8 : 1;
            m_ready <= 1'b0;
            n_acc   <= n_acc + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cmd_ready", int'(bus.cmd_ready), int'(m_ready));
         check("res_valid", int'(bus.res_valid), int'(m_rv));
         check("out",       int'(bus.out),       m.out);
         check("carry",     int'(bus.carry),     int'(m.carry));
         check("ovf",       int'(bus.ovf),       int'(m.ovf));
         check("zero",      int'(bus.zero),      int'(m.zero));
         check("err",       int'(bus.err),       int'(m.err));
         if (bus.res_valid) n_rv++;
      end
   end

   // Issue one command from a negedge; return at the negedge where res_valid is seen.
   task automatic do_cmd(input int op, input bit uas, input int a, input int b, input int exp_lat);
      bit got;
      int k;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op[2:0];
      bus.cmd_uas   = uas;
      bus.in1       = a[7:0];
      bus.in2       = b[7:0];
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (bus.cmd_ready) got = 1'b1;
         else @(negedge clk);
      end
      check("accepted", int'(got), 1);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.in1       = ~bus.in1;
      bus.in2       = ~bus.in2;
      got = 1'b0;
      k   = 1;
      while (!got && k < 20) begin
         if (bus.res_valid) got = 1'b1;
         else begin
            @(negedge clk);
            k++;
         end
      end
      check("res_valid seen", int'(got), 1);
      check("latency", k, exp_lat);
   endtask

   int mul_lat;
   int rv_snap;

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'd0;
      bus.cmd_uas   = 1'b0;
      bus.in1       = 8'd0;
      bus.in2       = 8'd0;
      mul_lat       = MUL_ON ? 9 : 2;
      #1 rst = 1'b0;
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);
      check("reset out", int'(bus.out), 0);
      check("reset cmd_ready", int'(bus.cmd_ready), 1);
      rst = 1'b1;
      @(negedge clk);

      do_cmd(0, 1'b0, 200, 100, 2);
      check("add out", int'(bus.out), 44);
      check("add carry", int'(bus.carry), 1);
      check("add zero", int'(bus.zero), 0);

      do_cmd(1, 1'b0, 5, 5, 2);
      check("sub zero", int'(bus.zero), 1);
      do_cmd(1, 1'b1, 1, 0, 2);
      check("sub borrow out", int'(bus.out), 255);
      check("sub borrow", int'(bus.carry), 1);

      do_cmd(2, 1'b0, 20, 13, mul_lat);
      check("mul1 out", int'(bus.out), MUL_ON ? 4 : 255);
      check("mul1 ovf", int'(bus.ovf), MUL_ON ? 1 : 0);
      check("mul1 err", int'(bus.err), MUL_ON ? 0 : 1);
      do_cmd(2, 1'b0, 7, 9, mul_lat);
      check("mul2 out", int'(bus.out), MUL_ON ? 63 : 255);

      do_cmd(3, 1'b0, 'hF0, 'h3C, 2);
      check("and out", int'(bus.out), 'h30);
      check("and err", int'(bus.err), 0);
      do_cmd(6, 1'b1, 'hFF, 0, 2);
      check("xor out", int'(bus.out), 'hCF);
      do_cmd(5, 1'b1, 0, 0, 2);
      check("not out", int'(bus.out), 'h30);
      do_cmd(7, 1'b0, 9, 9, 2);
      check("clr out", int'(bus.out), 0);
      check("clr zero", int'(bus.zero), 0);

      // Valid held mostly high with operands and ops changing every cycle.
      for (int c = 0; c < 300; c++) begin
         bus.cmd_valid = ($urandom_range(0, 9) != 0);
         bus.cmd_op    = 3'($urandom_range(0, 7));
         bus.cmd_uas   = 1'($urandom_range(0, 1));
         bus.in1       = 8'($urandom_range(0, 255));
         bus.in2       = 8'($urandom_range(0, 255));
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      repeat (12) @(negedge clk);
      check("one res_valid per accept", n_rv, n_acc);

      // Reset in the middle of a MUL.
      do_cmd(0, 1'b0, 3, 4, 2);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'd2;
      bus.cmd_uas   = 1'b0;
      bus.in1       = 8'd20;
      bus.in2       = 8'd13;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      rv_snap = n_rv;
      #2 rst = 1'b0;
      #1;
      check("abort out", int'(bus.out), 0);
      check("abort res_valid", int'(bus.res_valid), 0);
      check("abort cmd_ready", int'(bus.cmd_ready), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("ready after release", int'(bus.cmd_ready), 1);
      repeat (10) @(negedge clk);
      check("no res_valid after abort", n_rv - rv_snap, 0);

      do_cmd(0, 1'b0, 1, 1, 2);
      check("post-reset add", int'(bus.out), 2);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
